muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one bit per clock, WIDTH+1 cycles from start to done.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_count;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b_mag;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_div0;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic               w_accept;
   logic               w_last;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH+1:0]   w_trial;
   logic [WIDTH:0]     w_rem_next;
   logic [WIDTH-1:0]   w_quo_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_hi_res;
   logic [WIDTH-1:0]   w_lo_res;

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_count == CW'(WIDTH-1));

   // Both operations run on magnitudes; signs are reapplied on the final step
   assign w_a_neg = op[0] & a[WIDTH-1];
   assign w_b_neg = op[0] & b[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~a + ONE) : a;
   assign w_b_mag = w_b_neg ? (~b + ONE) : b;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // {r_rem, r_quo} is the product accumulator for multiply and the
   // partial-remainder/quotient pair for restoring divide
   always_comb begin
      w_add   = r_quo[0] ? (r_rem + {1'b0, r_b_mag}) : r_rem;
      w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
      w_trial = {1'b0, w_shift} - {2'b00, r_b_mag};
      if (r_op[1]) begin
         if (!w_trial[WIDTH+1]) begin
            w_rem_next = w_trial[WIDTH:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
         end else begin
            w_rem_next = w_shift;
            w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_rem_next = {1'b0, w_add[WIDTH:1]};
         w_quo_next = {w_add[0], r_quo[WIDTH-1:1]};
      end
   end

   assign w_prod     = {w_add, r_quo[WIDTH-1:1]};
   assign w_prod_fix = r_neg_res ? (~w_prod + ONE2) : w_prod;
   assign w_quo_fix  = r_neg_res ? (~w_quo_next + ONE) : w_quo_next;
   assign w_rem_fix  = r_neg_rem ? (~w_rem_next[WIDTH-1:0] + ONE) : w_rem_next[WIDTH-1:0];

   always_comb begin
      if (!r_op[1]) begin
         w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
         w_lo_res = w_prod_fix[WIDTH-1:0];
      end else if (r_div0) begin
         w_hi_res = r_a;
         w_lo_res = '1;
      end else begin
         w_hi_res = w_rem_fix;
         w_lo_res = w_quo_fix;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count   <= '0;
         r_op      <= '0;
         r_a       <= '0;
         r_b_mag   <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_dbz     <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else if (w_accept) begin
         r_count   <= '0;
         r_op      <= op;
         r_a       <= a;
         r_b_mag   <= w_b_mag;
         r_rem     <= '0;
         r_quo     <= w_a_mag;
         r_neg_res <= w_a_neg ^ w_b_neg;
         r_neg_rem <= w_a_neg;
         r_div0    <= op[1] && (b == '0);
         r_dbz     <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_rem   <= w_rem_next;
         r_quo   <= w_quo_next;
         r_count <= r_count + CW'(1);
         if (w_last) begin
            r_hi  <= w_hi_res;
            r_lo  <= w_lo_res;
            r_dbz <= r_div0;
         end
      end else begin
         if (hi_we) r_hi <= wdata;
         if (lo_we) r_lo <= wdata;
      end
   end

   assign dbz = r_dbz;
   assign hi  = r_hi;
   assign lo  = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed test of muldiv_unit at WIDTH=32: latency, busy window, signed and
// unsigned results, divide-by-zero, MTHI/MTLO writes and mid-run reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue start for one edge; returns in the first cycle after acceptance
   task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      tick();
      start = 1'b0;
      a     = 32'h0BAD_F00D;
      b     = 32'h0000_0003;
   endtask

   // cycles counts from the accepting edge; c0 is the cycle already reached
   task automatic wait_done(input int c0, output int cycles, output int busy_cnt);
      cycles   = c0;
      busy_cnt = 0;
      while (cycles < 100) begin
         if (busy) busy_cnt++;
         if (done) break;
         tick();
         cycles++;
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int cycles, output int busy_cnt);
      do_start(o, x, y);
      wait_done(1, cycles, busy_cnt);
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%b cycles=%0d", o, x, y, hi, lo, dbz, cycles);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      op = 2'b00; a = 32'd3; b = 32'd3;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (dbz !== 1'b0) begin n_errors++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
      n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      reset = 1'b0;
      tick();
      $display("reset released: busy=%b hi=%h lo=%h", busy, hi, lo);
   endtask

   task automatic test_multu();
      int cyc, bc;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bc);
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL multu_latency: got %0d expected 33", cyc); end
      n_checks++; if (bc !== 32) begin n_errors++; $display("FAIL multu_busy_cycles: got %0d expected 32", bc); end
      n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
      n_checks++; if (lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
      n_checks++; if (dbz !== 1'b0) begin n_errors++; $display("FAIL multu_dbz: got %b expected 0", dbz); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
   endtask

   task automatic test_mult();
      int cyc, bc;
      run_op(2'b01, 32'hFFFF_FFFD, 32'd5, cyc, bc);
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
   endtask

   task automatic test_divu();
      int cyc, bc;
      run_op(2'b10, 32'd100, 32'd7, cyc, bc);
      n_checks++; if (lo !== 32'd14) begin n_errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
      n_checks++; if (hi !== 32'd2) begin n_errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL divu_latency: got %0d expected 33", cyc); end
   endtask

   task automatic test_div();
      int cyc, bc;
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc, bc);
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bc);
      n_checks++; if (lo !== 32'h8000_0000) begin n_errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
      n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
      n_checks++; if (dbz !== 1'b0) begin n_errors++; $display("FAIL div_ovf_dbz: got %b expected 0", dbz); end
      run_op(2'b11, 32'd7, 32'hFFFF_FFFE, cyc, bc);
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_negdiv_lo: got %h expected fffffffd", lo); end
      n_checks++; if (hi !== 32'd1) begin n_errors++; $display("FAIL div_negdiv_hi: got %h expected 00000001", hi); end
   endtask

   task automatic test_dbz();
      int cyc, bc;
      run_op(2'b10, 32'd5, 32'd0, cyc, bc);
      n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
      n_checks++; if (hi !== 32'd5) begin n_errors++; $display("FAIL dbz_hi: got %h expected 00000005", hi); end
      n_checks++; if (dbz !== 1'b1) begin n_errors++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL dbz_latency: got %0d expected 33", cyc); end
      tick();
      n_checks++; if (dbz !== 1'b1) begin n_errors++; $display("FAIL dbz_hold: got %b expected 1", dbz); end
      do_start(2'b00, 32'd2, 32'd3);
      n_checks++; if (dbz !== 1'b0) begin n_errors++; $display("FAIL dbz_clear: got %b expected 0", dbz); end
      wait_done(1, cyc, bc);
      $display("op=0 a=00000002 b=00000003 -> hi=%h lo=%h dbz=%b cycles=%0d", hi, lo, dbz, cyc);
      n_checks++; if (lo !== 32'd6) begin n_errors++; $display("FAIL dbz_next_lo: got %h expected 00000006", lo); end
   endtask

   task automatic test_ignore_busy();
      int cyc, bc;
      do_start(2'b00, 32'd6, 32'd7);
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      repeat (3) tick();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL busy_run: got %b expected 1", busy); end
      n_checks++; if (lo !== 32'd6) begin n_errors++; $display("FAIL run_lo_hold: got %h expected 00000006", lo); end
      n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL run_hi_hold: got %h expected 00000000", hi); end
      wait_done(4, cyc, bc);
      $display("op=0 a=00000006 b=00000007 (busy writes) -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
      n_checks++; if (lo !== 32'd42) begin n_errors++; $display("FAIL ignore_lo: got %h expected 0000002a", lo); end
      n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL ignore_latency: got %0d expected 33", cyc); end
   endtask

   task automatic test_mthi_mtlo();
      int cyc, bc;
      tick();
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
      tick();
      hi_we = 1'b0; lo_we = 1'b0;
      $display("mthi/mtlo wdata=12345678 -> hi=%h lo=%h", hi, lo);
      n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL mthi: got %h expected 12345678", hi); end
      n_checks++; if (lo !== 32'h1234_5678) begin n_errors++; $display("FAIL mtlo: got %h expected 12345678", lo); end
      hi_we = 1'b1; wdata = 32'h0000_AAAA;
      do_start(2'b00, 32'd3, 32'd3);
      hi_we = 1'b0;
      n_checks++; if (hi !== 32'h1234_5678) begin n_errors++; $display("FAIL start_prio_hi: got %h expected 12345678", hi); end
      wait_done(1, cyc, bc);
      $display("op=0 a=00000003 b=00000003 (start+mthi) -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
      n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL start_prio_done_hi: got %h expected 00000000", hi); end
      n_checks++; if (lo !== 32'd9) begin n_errors++; $display("FAIL start_prio_done_lo: got %h expected 00000009", lo); end
   endtask

   task automatic test_reset_mid_run();
      int cyc, bc;
      logic seen_done;
      seen_done = 1'b0;
      tick();
      do_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) tick();
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL midreset_hi: got %h expected 00000000", hi); end
      n_checks++; if (lo !== 32'd0) begin n_errors++; $display("FAIL midreset_lo: got %h expected 00000000", lo); end
      repeat (2) begin tick(); if (done) seen_done = 1'b1; end
      reset = 1'b0;
      repeat (40) begin tick(); if (done) seen_done = 1'b1; end
      $display("reset in run cycle 10 -> busy=%b hi=%h lo=%h", busy, hi, lo);
      n_checks++; if (seen_done !== 1'b0) begin n_errors++; $display("FAIL midreset_no_done: got %b expected 0", seen_done); end
      run_op(2'b00, 32'd7, 32'd8, cyc, bc);
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL after_reset_latency: got %0d expected 33", cyc); end
      n_checks++; if (lo !== 32'd56) begin n_errors++; $display("FAIL after_reset_lo: got %h expected 00000038", lo); end
   endtask

   task automatic test_back_to_back();
      int cyc, bc;
      // Start held while done is high re-enters RUN without an idle cycle
      do_start(2'b10, 32'd1000, 32'd10);
      wait_done(1, cyc, bc);
      start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFE; b = 32'hFFFF_FFFD;
      tick();
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      wait_done(1, cyc, bc);
      $display("op=1 a=fffffffe b=fffffffd (back-to-back) -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
      n_checks++; if (lo !== 32'd6) begin n_errors++; $display("FAIL b2b_lo: got %h expected 00000006", lo); end
      n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL b2b_hi: got %h expected 00000000", hi); end
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_divu();
      test_div();
      test_dbz();
      test_ignore_busy();
      test_mthi_mtlo();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
